led_sequencer: RTL and testbench

- Runtime-configurable, multi-channel LED pattern engine.
- Each channel selects one timebase tap (a one-cycle tick strobe) and a divider, and runs in mode OFF, ON, BLINK or FLASH.
- Configured through a valid/ready write port; a global sync input realigns all blink phases.
- Sits between the shared timebase and the board LED pins, replacing fixed compile-time blinkers.

---
 rtl/led_sequencer.sv | 142 ++++++++++++++
 tb/tb_led_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// Multi-channel LED pattern engine: each channel picks a timebase tap and divider
// and runs OFF / ON / BLINK / FLASH, configured through a valid/ready write port.
//
//   mode       | meaning
//   -----------+-----------------------------------------------------------
//   MODE_OFF   | led low, ticks ignored, cnt held at 0
//   MODE_ON    | led high, ticks ignored, cnt held at 0
//   MODE_BLINK | led toggles every div ticks, high phase first
//   MODE_FLASH | led high and busy until div ticks elapse, then drops to OFF
module led_sequencer #(
   parameter int NCH   = 3,
   parameter int NTAPS = 6,
   parameter int DIV_W = 8,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NTAPS-1:0] taps,
   input  logic             sync,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [TAP_W-1:0] cfg_tap,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_err,
   output logic [NCH-1:0]   led_out,
   output logic [NCH-1:0]   busy
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_FLASH = 2'd3
   } mode_t;

   mode_t            mode_q [NCH];
   mode_t            mode_d [NCH];
   logic [TAP_W-1:0] tap_q  [NCH];
   logic [TAP_W-1:0] tap_d  [NCH];
   logic [DIV_W-1:0] div_q  [NCH];
   logic [DIV_W-1:0] div_d  [NCH];
   logic [DIV_W-1:0] cnt_q  [NCH];
   logic [DIV_W-1:0] cnt_d  [NCH];
   logic [NCH-1:0]   led_q, led_d;
   logic [NCH-1:0]   busy_q, busy_d;
   logic [NCH-1:0]   tick;
   logic             ready_q;
   logic             err_q, err_d;
   logic             accept;
   logic             ch_ok;
   mode_t            cfg_mode_t;
   logic [TAP_W-1:0] tap_clamped;
   logic [DIV_W-1:0] div_clamped;

   assign accept      = cfg_valid & ready_q;
   assign ch_ok       = ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));
   assign cfg_mode_t  = mode_t'(cfg_mode);
   // Compare one bit wider so a power-of-two NTAPS does not truncate to zero.
   assign tap_clamped = ({1'b0, cfg_tap} >= (TAP_W + 1)'(NTAPS)) ? TAP_W'(NTAPS - 1) : cfg_tap;
   assign div_clamped = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;
   assign led_out   = led_q;
   assign busy      = busy_q;

   always_comb begin
      tick = '0;
      for (int i = 0; i < NCH; i++) begin
         tick[i] = taps[tap_q[i]];
      end
   end

   // Priority per channel: config write, then sync, then tick.
   always_comb begin
      err_d  = accept & ~ch_ok;
      led_d  = led_q;
      busy_d = busy_q;
      for (int i = 0; i < NCH; i++) begin
         mode_d[i] = mode_q[i];
         tap_d[i]  = tap_q[i];
         div_d[i]  = div_q[i];
         cnt_d[i]  = cnt_q[i];
         if (accept && ch_ok && (cfg_ch == CH_W'(i))) begin
            mode_d[i] = cfg_mode_t;
            tap_d[i]  = tap_clamped;
            div_d[i]  = div_clamped;
            cnt_d[i]  = '0;
            led_d[i]  = (cfg_mode_t != MODE_OFF);
            busy_d[i] = (cfg_mode_t == MODE_FLASH);
         end else if (sync) begin
            cnt_d[i] = '0;
            if (mode_q[i] == MODE_BLINK) begin
               led_d[i] = 1'b1;
            end
         end else if (tick[i] && ((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_FLASH))) begin
            if (cnt_q[i] == (div_q[i] - DIV_W'(1))) begin
               cnt_d[i] = '0;
               if (mode_q[i] == MODE_BLINK) begin
                  led_d[i] = ~led_q[i];
               end else begin
                  led_d[i]  = 1'b0;
                  busy_d[i] = 1'b0;
                  mode_d[i] = MODE_OFF;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         led_q   <= '0;
         busy_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            mode_q[i] <= MODE_OFF;
            tap_q[i]  <= '0;
            div_q[i]  <= DIV_W'(1);
            cnt_q[i]  <= '0;
         end
      end else begin
         ready_q <= 1'b1;
         err_q   <= err_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         for (int i = 0; i < NCH; i++) begin
            mode_q[i] <= mode_d[i];
            tap_q[i]  <= tap_d[i];
            div_q[i]  <= div_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed plus randomized bench for led_sequencer; a tick-count reference model
// predicts every output each cycle.
module tb_led_sequencer;
   localparam int NCH   = 3;
   localparam int NTAPS = 6;
   localparam int DIV_W = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] taps;
   logic       sync;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [1:0] cfg_mode;
   logic [2:0] cfg_tap;
   logic [7:0] cfg_div;
   logic       cfg_err;
   logic [2:0] led_out;
   logic [2:0] busy;

   int total = 0;
   int bad   = 0;

   // Model state: mode, tap, div and ticks elapsed since config or sync.
   int m_mode [NCH];
   int m_tap  [NCH];
   int m_div  [NCH];
   int m_t    [NCH];
   int m_ready;
   int m_err;

   led_sequencer #(.NCH(NCH), .NTAPS(NTAPS), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .taps(taps), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_mode(cfg_mode), .cfg_tap(cfg_tap), .cfg_div(cfg_div),
      .cfg_err(cfg_err), .led_out(led_out), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void model_step();
      bit acc;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_tap[c] = 0; m_div[c] = 1; m_t[c] = 0;
         end
         m_ready = 0;
         m_err   = 0;
         return;
      end
      acc   = cfg_valid && (m_ready != 0);
      m_err = (acc && int'(cfg_ch) >= NCH) ? 1 : 0;
      for (int c = 0; c < NCH; c++) begin
         if (acc && int'(cfg_ch) == c) begin
            m_mode[c] = int'(cfg_mode);
            m_tap[c]  = (int'(cfg_tap) > NTAPS - 1) ? NTAPS - 1 : int'(cfg_tap);
            m_div[c]  = (cfg_div == 0) ? 1 : int'(cfg_div);
            m_t[c]    = 0;
         end else if (sync) begin
            m_t[c] = 0;
         end else if (taps[m_tap[c]] && m_mode[c] >= 2) begin
            m_t[c] = m_t[c] + 1;
            if (m_mode[c] == 3 && m_t[c] >= m_div[c]) begin
               m_mode[c] = 0;
               m_t[c]    = 0;
            end
         end
      end
      m_ready = 1;
   endfunction

   function automatic logic [2:0] exp_led();
      logic [2:0] v = '0;
      for (int c = 0; c < NCH; c++) begin
         case (m_mode[c])
            1, 3:    v[c] = 1'b1;
            2:       v[c] = ((m_t[c] / m_div[c]) % 2) == 0;
            default: v[c] = 1'b0;
         endcase
      end
      return v;
   endfunction

   function automatic logic [2:0] exp_busy();
      logic [2:0] v = '0;
      for (int c = 0; c < NCH; c++) v[c] = (m_mode[c] == 3);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("led_out", 32'(led_out), 32'(exp_led()));
      chk("busy", 32'(busy), 32'(exp_busy()));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
   endtask

   task automatic write(input int ch, input int mode, input int tap, input int div);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_mode  = 2'(mode);
      cfg_tap   = 3'(tap);
      cfg_div   = 8'(div);
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      int p;
      logic [2:0] led_prev;
      rst = 1'b1; taps = '0; sync = 1'b0;
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_tap = 3'd0; cfg_div = 8'd1;

      // Reset held with a pending write that must be ignored.
      repeat (3) step();
      chk("rst_led", 32'(led_out), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0; cfg_valid = 1'b0;
      step();
      chk("ready_rise", 32'(cfg_ready), 32'd1);
      chk("rst_write_ignored", 32'(led_out), 32'd0);

      // BLINK ch0 tap2 div3; taps[1] every cycle must be ignored.
      write(0, 2, 2, 3);
      chk("blink_start", 32'(led_out[0]), 32'd1);
      p = 0;
      for (int c = 0; c < 28; c++) begin
         taps = 6'b000010 | ((c % 4 == 0) ? 6'b000100 : 6'b000000);
         step();
         if (taps[2]) p++;
         if (taps[2] && p == 3) chk("blink_3rd", 32'(led_out[0]), 32'd0);
         if (taps[2] && p == 6) chk("blink_6th", 32'(led_out[0]), 32'd1);
      end
      taps = '0;

      // FLASH ch1 tap0 div2.
      write(1, 3, 0, 2);
      chk("flash_led", 32'(led_out[1]), 32'd1);
      chk("flash_busy", 32'(busy[1]), 32'd1);
      p = 0;
      for (int c = 0; c < 12; c++) begin
         taps = (c % 3 == 0) ? 6'b000001 : 6'b000000;
         step();
         if (taps[0]) p++;
         if (taps[0] && p == 1) chk("flash_mid", 32'(busy[1]), 32'd1);
         if (taps[0] && p == 2) chk("flash_end", 32'({led_out[1], busy[1]}), 32'd0);
      end
      taps = '0;

      // Clamps: div 0 -> 1, tap 7 -> 5.
      write(2, 2, 7, 0);
      p = 0;
      for (int c = 0; c < 10; c++) begin
         taps = (c % 2 == 1) ? 6'b100000 : 6'b000000;
         step();
         if (taps[5]) begin
            p++;
            chk("clamp_toggle", 32'(led_out[2]), 32'(p % 2 == 0));
         end
      end
      taps = '0;

      // Sync collides with a tick: sync wins.
      write(0, 2, 2, 4);
      for (int c = 0; c < 12; c++) begin
         taps = (c % 2 == 0) ? 6'b000100 : 6'b000000;
         step();
      end
      chk("sync_pre", 32'(led_out[0]), 32'd0);
      sync = 1'b1; taps = 6'b000100;
      step();
      sync = 1'b0; taps = '0;
      chk("sync_led", 32'(led_out[0]), 32'd1);
      p = 0;
      for (int c = 0; c < 8; c++) begin
         taps = (c % 2 == 0) ? 6'b000100 : 6'b000000;
         step();
         if (taps[2]) p++;
         if (taps[2] && p == 3) chk("sync_hold", 32'(led_out[0]), 32'd1);
         if (taps[2] && p == 4) chk("sync_toggle", 32'(led_out[0]), 32'd0);
      end
      taps = '0;

      // Write to a nonexistent channel.
      led_prev = led_out;
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd1; cfg_tap = 3'd0; cfg_div = 8'd1;
      step();
      cfg_valid = 1'b0;
      chk("err_pulse", 32'(cfg_err), 32'd1);
      chk("err_no_change", 32'(led_out), 32'(led_prev));
      step();
      chk("err_clear", 32'(cfg_err), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         taps      = 6'($urandom & $urandom) & 6'h3f;
         sync      = ($urandom_range(0, 19) == 0);
         cfg_valid = ($urandom_range(0, 7) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_mode  = 2'($urandom_range(0, 3));
         cfg_tap   = 3'($urandom_range(0, 7));
         cfg_div   = 8'($urandom_range(0, 4));
         step();
      end
      taps = '0; sync = 1'b0; cfg_valid = 1'b0;

      // Reset mid-blink.
      write(0, 2, 1, 1);
      repeat (3) begin taps = 6'b000010; step(); end
      rst = 1'b1;
      step();
      chk("rst_mid_led", 32'(led_out), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         taps = 6'($urandom) & 6'h3f;
         step();
         chk("post_rst_quiet", 32'(led_out), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
